// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered ALU with valid/ready handshakes on both sides.
//
// One operation is in flight at a time. Add and the logic ops finish one edge
// after acceptance. Shifts take their amount from operand1[SHAMT_W-1:0] and
// run one bit per cycle, so a shift by k finishes k+1 edges after acceptance.
// The NOP code is accepted and produces no result.
//
// Optional build macro: ALU_FLAGS_EN
//   When defined, a registered {N,Z,C,V} flags port is added and updated
//   together with result. When undefined, the port and the carry/overflow
//   logic are absent.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request
//   in_ready   block can accept an operation (IDLE and out of reset)
//   funcSel    000 add, 001 xor, 010 and, 011 or, 100 nor,
//              101 logical shift right, 110 logical shift left, 111 NOP
//   operand0   first operand; value to be shifted for shift ops
//   operand1   second operand; [SHAMT_W-1:0] is the shift amount
//   out_valid  result available
//   out_ready  downstream accepts result
//   result     registered result
//   flags      {N,Z,C,V} (ALU_FLAGS_EN only)
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funcSel,
  input  logic [WIDTH-1:0] operand0,
  input  logic [WIDTH-1:0] operand1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_left;
  logic [WIDTH-1:0]   r_result;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_is_shift;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_shift_now;
  logic               w_shift_last;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH-1:0]   w_comb_result;
  logic [WIDTH-1:0]   w_acc_shifted;

  // ---------------------------------------------------------------------------
  // Operation decode and single-cycle datapath
  // ---------------------------------------------------------------------------
  assign w_accept     = in_valid & in_ready;
  assign w_is_shift   = (funcSel == OP_SRL) || (funcSel == OP_SLL);
  assign w_shamt      = operand1[SHAMT_W-1:0];
  // A shift by zero takes the single-cycle path and returns operand0.
  assign w_shift_now  = w_is_shift && (w_shamt != '0);
  assign w_shift_last = (r_cnt == SHAMT_W'(1));

`ifdef ALU_FLAGS_EN
  logic w_add_c;
  logic w_add_v;
  logic w_shift_out;
  assign {w_add_c, w_add} = {1'b0, operand0} + {1'b0, operand1};
  // Signed overflow: operands agree in sign, sum disagrees.
  assign w_add_v = (operand0[WIDTH-1] == operand1[WIDTH-1]) &&
                   (w_add[WIDTH-1] != operand0[WIDTH-1]);
  // Bit falling off the accumulator on this shift step.
  assign w_shift_out = r_left ? r_acc[WIDTH-1] : r_acc[0];
`else
  assign w_add = operand0 + operand1;
`endif

  always_comb begin
    w_comb_result = '0;
    case (funcSel)
      OP_ADD:  w_comb_result = w_add;
      OP_XOR:  w_comb_result = operand0 ^ operand1;
      OP_AND:  w_comb_result = operand0 & operand1;
      OP_OR:   w_comb_result = operand0 | operand1;
      OP_NOR:  w_comb_result = ~(operand0 | operand1);
      OP_SRL:  w_comb_result = operand0;
      OP_SLL:  w_comb_result = operand0;
      default: w_comb_result = '0;
    endcase
  end

  assign w_acc_shifted = r_left ? (r_acc << 1) : (r_acc >> 1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (funcSel != OP_NOP)) begin
          w_state_next = w_shift_now ? S_SHIFT : S_OUT;
        end
      end
      S_SHIFT: begin
        if (w_shift_last) begin
          w_state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = (r_state == S_IDLE) && rst_n;
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
`ifdef ALU_FLAGS_EN
  logic [3:0] r_flags;
  assign flags = r_flags;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_left      <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
      r_flags     <= 4'b0000;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (funcSel != OP_NOP)) begin
            if (w_shift_now) begin
              r_acc  <= operand0;
              r_cnt  <= w_shamt;
              r_left <= (funcSel == OP_SLL);
            end else begin
              r_result    <= w_comb_result;
              r_out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
              r_flags <= {w_comb_result[WIDTH-1],
                          (w_comb_result == '0),
                          (funcSel == OP_ADD) && w_add_c,
                          (funcSel == OP_ADD) && w_add_v};
`endif
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_shifted;
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (w_shift_last) begin
            r_result    <= w_acc_shifted;
            r_out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
            r_flags <= {w_acc_shifted[WIDTH-1],
                        (w_acc_shifted == '0),
                        w_shift_out,
                        1'b0};
`endif
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
